dcache_wbuf: RTL and testbench

- Write buffer plus memory-port arbiter between the data cache's memory interface and the system bus.
- Absorbs write-through stores so cache write hits complete without stalling.
- Drains queued stores to the bus in order.
- Holds line-fill reads until all older stores are committed, which preserves read-after-write ordering.

---
 rtl/dcache_wbuf.sv | 132 +++++++++++++
 tb/tb_dcache_wbuf.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wbuf.sv
// Write buffer and memory-port arbiter between the data cache and the system bus.
// Stores are queued and drained in order; fill reads wait until every older store is committed.
module dcache_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_wstrb,
  output logic [31:0]       c_rdata,
  output logic              c_valid,
  output logic              wb_full,
  output logic              wb_empty,
  output logic              wb_ovf,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_valid
);

  // state   | meaning
  // S_IDLE  | no bus request; pick the next store, else a pending fill read
  // S_WRITE | head store on the bus, popped on bus_valid
  // S_READ  | fill read on the bus, data passed straight to the cache
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_e;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count;
  logic             ovf_q, ovf_d;
  logic             push, pop;

  logic [ADDR_W-3:0] addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [3:0]        strb_mem [DEPTH];
  logic [IDX_W-1:0]  head_idx;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^c_addr[1:0];

  assign count    = wr_ptr_q - rd_ptr_q;
  assign head_idx = rd_ptr_q[IDX_W-1:0];
  assign pop      = (state_q == S_WRITE) && bus_valid;
  // A full buffer still accepts a store when the head retires in the same cycle.
  assign push     = c_wr && ((count != PTR_W'(DEPTH)) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (c_wr && !push) ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (count != '0)  state_d = S_WRITE;
        else if (c_rd)    state_d = S_READ;
      end
      S_WRITE: if (bus_valid) state_d = S_IDLE;
      S_READ:  if (bus_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_addr  = '0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = '0;
    bus_wstrb = '0;
    c_rdata   = '0;
    c_valid   = 1'b0;
    unique case (state_q)
      S_WRITE: begin
        bus_wr    = 1'b1;
        bus_addr  = {addr_mem[head_idx], 2'b00};
        bus_wdata = data_mem[head_idx];
        bus_wstrb = strb_mem[head_idx];
      end
      S_READ: begin
        bus_rd   = 1'b1;
        bus_addr = c_addr;
        c_rdata  = bus_rdata;
        c_valid  = bus_valid;
      end
      default: ;
    endcase
  end

  assign wb_full  = (count == PTR_W'(DEPTH));
  assign wb_empty = (count == '0) && (state_q != S_WRITE);
  assign wb_ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[IDX_W-1:0]] <= c_addr[ADDR_W-1:2];
      data_mem[wr_ptr_q[IDX_W-1:0]] <= c_wdata;
      strb_mem[wr_ptr_q[IDX_W-1:0]] <= c_wstrb;
    end
  end

endmodule

// File: tb/tb_dcache_wbuf.sv
// Directed bench for dcache_wbuf: store drain order, overflow, push/pop at full,
// read-after-write ordering and mid-transaction reset.
module tb_dcache_wbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] c_addr = '0;
  logic        c_rd = 1'b0;
  logic        c_wr = 1'b0;
  logic [31:0] c_wdata = '0;
  logic [3:0]  c_wstrb = '0;
  logic [31:0] c_rdata;
  logic        c_valid;
  logic        wb_full, wb_empty, wb_ovf;
  logic [31:0] bus_addr;
  logic        bus_rd, bus_wr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = '0;
  logic        bus_valid = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [3:0]  log_strb [64];
  int          log_n = 0;

  dcache_wbuf #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_addr(c_addr), .c_rd(c_rd), .c_wr(c_wr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_rdata(c_rdata), .c_valid(c_valid),
    .wb_full(wb_full), .wb_empty(wb_empty), .wb_ovf(wb_ovf),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  // Completed bus writes, sampled mid-cycle while request and completion are both stable.
  always @(negedge clk) begin
    if (rst_n && bus_wr && bus_valid && log_n < 64) begin
      log_addr[log_n] = bus_addr;
      log_data[log_n] = bus_wdata;
      log_strb[log_n] = bus_wstrb;
      log_n = log_n + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
    bus_valid = 1'b0; bus_rdata = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    c_wr = 1'b1; c_addr = a; c_wdata = d; c_wstrb = s;
    step();
    c_wr = 1'b0;
  endtask

  // Waits (bounded) for bus_wr, then completes the transfer after dly cycles.
  task automatic serve_write(input int dly);
    int n = 0;
    while (!bus_wr && n < 50) begin
      step();
      n++;
    end
    total++;
    if (bus_wr !== 1'b1) begin
      bad++;
      $display("FAIL serve_write_timeout: bus_wr=%b required 1", bus_wr);
    end
    for (int i = 0; i < dly; i++) step();
    bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({wb_empty, wb_full, bus_rd, bus_wr, wb_ovf, c_valid} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_outputs: empty/full/rd/wr/ovf/cvalid=%b required 100000",
               {wb_empty, wb_full, bus_rd, bus_wr, wb_ovf, c_valid});
    end
    do_reset();
    step();
    step();
    total++;
    if ({wb_empty, wb_full, bus_rd, bus_wr, wb_ovf, c_valid} !== 6'b100000) begin
      bad++;
      $display("FAIL idle_outputs: empty/full/rd/wr/ovf/cvalid=%b required 100000",
               {wb_empty, wb_full, bus_rd, bus_wr, wb_ovf, c_valid});
    end
    total++;
    if (bus_addr !== 32'h0) begin
      bad++;
      $display("FAIL idle_bus_addr: got %h required 00000000", bus_addr);
    end
  endtask

  task automatic test_single_store();
    int base;
    int n = 0;
    do_reset();
    base = log_n;
    store(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    total++;
    if (wb_empty !== 1'b0) begin
      bad++;
      $display("FAIL single_not_empty: wb_empty=%b required 0", wb_empty);
    end
    while (!bus_wr && n < 20) begin
      step();
      n++;
    end
    total++;
    if ({bus_wr, bus_addr, bus_wdata, bus_wstrb} !== {1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
      bad++;
      $display("FAIL single_bus_req: wr=%b addr=%h data=%h strb=%h required 1 00001000 deadbeef f",
               bus_wr, bus_addr, bus_wdata, bus_wstrb);
    end
    step();
    step();
    total++;
    if ({bus_wr, bus_rd, bus_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
      bad++;
      $display("FAIL single_hold: wr=%b rd=%b addr=%h required 1 0 00001000", bus_wr, bus_rd, bus_addr);
    end
    bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    total++;
    if ({wb_empty, bus_wr} !== 2'b10) begin
      bad++;
      $display("FAIL single_done: empty/wr=%b required 10", {wb_empty, bus_wr});
    end
    step();
    step();
    total++;
    if (log_n - base !== 1 || log_addr[base] !== 32'h1000 || log_data[base] !== 32'hDEAD_BEEF
        || log_strb[base] !== 4'hF) begin
      bad++;
      $display("FAIL single_log: writes=%0d addr=%h data=%h required 1 00001000 deadbeef",
               log_n - base, log_addr[base], log_data[base]);
    end
  endtask

  task automatic test_full_overflow();
    int base;
    logic [31:0] exp_a;
    do_reset();
    base = log_n;
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
    total++;
    if ({wb_full, wb_ovf, bus_wr} !== 3'b101) begin
      bad++;
      $display("FAIL full_flag: full/ovf/wr=%b required 101", {wb_full, wb_ovf, bus_wr});
    end
    store(32'h24, 32'hBAD0_0000, 4'hF);
    total++;
    if ({wb_full, wb_ovf} !== 2'b11) begin
      bad++;
      $display("FAIL overflow_flag: full/ovf=%b required 11", {wb_full, wb_ovf});
    end
    for (int i = 0; i < 4; i++) serve_write(1);
    step();
    for (int i = 0; i < 4; i++) begin
      exp_a = 32'h10 + 32'(i * 4);
      total++;
      if (log_addr[base + i] !== exp_a || log_data[base + i] !== 32'hA000_0000 + 32'(i)) begin
        bad++;
        $display("FAIL drain_order[%0d]: addr=%h data=%h required %h %h",
                 i, log_addr[base + i], log_data[base + i], exp_a, 32'hA000_0000 + 32'(i));
      end
    end
    total++;
    if ({log_n - base, wb_empty, wb_ovf} !== {32'd4, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL drain_end: writes=%0d empty=%b ovf=%b required 4 1 1", log_n - base, wb_empty, wb_ovf);
    end
  endtask

  task automatic test_push_pop_full();
    int base;
    logic [31:0] exp_a;
    do_reset();
    base = log_n;
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'h3);
    total++;
    if ({wb_full, bus_wr} !== 2'b11) begin
      bad++;
      $display("FAIL pp_pre: full/wr=%b required 11", {wb_full, bus_wr});
    end
    c_wr = 1'b1; c_addr = 32'h20; c_wdata = 32'hB000_0004; c_wstrb = 4'h3;
    bus_valid = 1'b1;
    step();
    c_wr = 1'b0;
    bus_valid = 1'b0;
    total++;
    if ({wb_full, wb_ovf} !== 2'b10) begin
      bad++;
      $display("FAIL pp_count: full/ovf=%b required 10", {wb_full, wb_ovf});
    end
    for (int i = 0; i < 4; i++) serve_write(0);
    step();
    for (int i = 0; i < 5; i++) begin
      exp_a = 32'h10 + 32'(i * 4);
      total++;
      if (log_addr[base + i] !== exp_a || log_strb[base + i] !== 4'h3) begin
        bad++;
        $display("FAIL pp_order[%0d]: addr=%h strb=%h required %h 3", i, log_addr[base + i],
                 log_strb[base + i], exp_a);
      end
    end
    total++;
    if ({log_n - base, wb_empty, wb_ovf} !== {32'd5, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL pp_end: writes=%0d empty=%b ovf=%b required 5 1 0", log_n - base, wb_empty, wb_ovf);
    end
  endtask

  task automatic test_read_after_write();
    int base;
    int n;
    logic rd_early;
    do_reset();
    base = log_n;
    rd_early = 1'b0;
    store(32'h30, 32'h1111_1111, 4'hF);
    store(32'h34, 32'h2222_2222, 4'hF);
    c_rd = 1'b1; c_addr = 32'h40;
    for (int w = 0; w < 2; w++) begin
      n = 0;
      while (!bus_wr && n < 20) begin
        if (bus_rd) rd_early = 1'b1;
        step();
        n++;
      end
      if (bus_rd) rd_early = 1'b1;
      step();
      bus_valid = 1'b1;
      step();
      bus_valid = 1'b0;
      if (bus_rd) rd_early = 1'b1;
    end
    total++;
    if (rd_early !== 1'b0 || log_n - base !== 2) begin
      bad++;
      $display("FAIL raw_order: read_before_writes=%b writes=%0d required 0 2", rd_early, log_n - base);
    end
    n = 0;
    while (!bus_rd && n < 20) begin
      step();
      n++;
    end
    total++;
    if ({bus_rd, bus_wr, bus_addr, c_valid} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
      bad++;
      $display("FAIL raw_read_req: rd=%b wr=%b addr=%h cvalid=%b required 1 0 00000040 0",
               bus_rd, bus_wr, bus_addr, c_valid);
    end
    bus_rdata = 32'h1234_5678;
    bus_valid = 1'b1;
    #1;
    total++;
    if ({c_valid, c_rdata} !== {1'b1, 32'h1234_5678}) begin
      bad++;
      $display("FAIL raw_rdata: cvalid=%b rdata=%h required 1 12345678", c_valid, c_rdata);
    end
    step();
    bus_valid = 1'b0;
    c_rd = 1'b0;
    #1;
    total++;
    if ({c_valid, bus_rd, c_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL raw_after: cvalid=%b rd=%b rdata=%h required 0 0 00000000", c_valid, bus_rd, c_rdata);
    end
  endtask

  task automatic test_reset_midway();
    int base;
    int n = 0;
    logic wr_seen;
    do_reset();
    for (int i = 0; i < 3; i++) store(32'h50 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF);
    while (!bus_wr && n < 20) begin
      step();
      n++;
    end
    total++;
    if (bus_wr !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: bus_wr=%b required 1", bus_wr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus_wr, wb_empty, wb_full} !== 3'b010) begin
      bad++;
      $display("FAIL mid_reset: wr/empty/full=%b required 010", {bus_wr, wb_empty, wb_full});
    end
    step();
    rst_n = 1'b1;
    base = log_n;
    wr_seen = 1'b0;
    bus_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_wr || !wb_empty) wr_seen = 1'b1;
    end
    bus_valid = 1'b0;
    total++;
    if ({wr_seen, log_n - base} !== {1'b0, 32'd0}) begin
      bad++;
      $display("FAIL mid_after: write_activity=%b writes=%0d required 0 0", wr_seen, log_n - base);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full_overflow();
    test_push_pop_full();
    test_read_after_write();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
